btb_update_ctrl: RTL

Write-port controller for the branch target buffer. It clears every BTB entry after reset or on a flush by sweeping invalid writes, then merges branch-resolution updates from two backend requesters into the BTB's single write port. Updates are buffered in a small FIFO and drained at one write per cycle. It sits between the backend branch-resolve logic and the BTB RAM write port. It tells fetch when BTB lookups are untrustworthy.

---
 rtl/btb_update_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: invalidation sweep after reset/flush, then drains
// buffered branch-resolution updates from two requesters at one write per cycle.
// Latency: an update accepted in cycle t with an empty FIFO is written in t+1.
// Backpressure: ready is computed from FIFO free space at the start of the
// cycle; requester 1 loses first when both compete for the last slot.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush_i                       drop queued updates, restart the sweep
//   req{0,1}_valid_i/_ready_o     update handshake (req0 has priority)
//   req{0,1}_pc_i/_bta_i/_br_type_i  update payload (pc/target are [31:2])
//   btb_we_o, btb_wpc_o, btb_bta_o, btb_br_type_o, btb_valid_o  BTB write port
//   busy_o                        sweep in progress, BTB lookups untrustworthy
module btb_update_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [29:0] req0_pc_i,
    input  logic [29:0] req0_bta_i,
    input  logic [1:0]  req0_br_type_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [29:0] req1_pc_i,
    input  logic [29:0] req1_bta_i,
    input  logic [1:0]  req1_br_type_i,
    output logic        btb_we_o,
    output logic [29:0] btb_wpc_o,
    output logic [29:0] btb_bta_o,
    output logic [1:0]  btb_br_type_o,
    output logic        btb_valid_o,
    output logic        busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {SWEEP, RUN} state_t;

    typedef struct packed {
        logic [29:0] pc;
        logic [29:0] bta;
        logic [1:0]  br_type;
    } upd_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    upd_t                  mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr1;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  run;
    logic                  head_vld;
    logic                  acc0;
    logic                  acc1;
    upd_t                  head;

    assign run      = (state == RUN);
    assign free     = CW'(FIFO_DEPTH) - count;
    assign head_vld = run && (count != '0);
    assign head     = mem[rd_ptr];

    // Ready is gated by flush and rst so nothing is accepted in a cycle whose
    // queue contents are about to be thrown away.
    assign req0_ready_o = run && !flush_i && !rst && (free >= CW'(1));
    assign req1_ready_o = run && !flush_i && !rst &&
                          (req0_valid_i ? (free >= CW'(2)) : (free >= CW'(1)));

    assign acc0 = req0_valid_i && req0_ready_o;
    assign acc1 = req1_valid_i && req1_ready_o;

    // req1 lands behind req0 when both are accepted together.
    assign wr_ptr1 = wr_ptr + PW'(acc0);

    assign busy_o = !run;

    always_comb begin
        btb_we_o      = 1'b0;
        btb_valid_o   = 1'b0;
        btb_wpc_o     = '0;
        btb_bta_o     = '0;
        btb_br_type_o = '0;
        if (!run) begin
            // Sweep index sits in pc[ADDR_WIDTH+2:3], i.e. wpc[ADDR_WIDTH:1].
            btb_we_o                  = 1'b1;
            btb_wpc_o[ADDR_WIDTH:1]   = cnt;
        end else if (head_vld) begin
            btb_we_o      = 1'b1;
            btb_valid_o   = 1'b1;
            btb_wpc_o     = head.pc;
            btb_bta_o     = head.bta;
            btb_br_type_o = head.br_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state  <= SWEEP;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == SWEEP) begin
            cnt <= cnt + ADDR_WIDTH'(1);
            if (cnt == '1) begin
                state <= RUN;
            end
        end else begin
            wr_ptr <= wr_ptr + PW'(acc0) + PW'(acc1);
            rd_ptr <= rd_ptr + PW'(head_vld);
            count  <= count + CW'(acc0) + CW'(acc1) - CW'(head_vld);
        end
    end

    // Payload storage needs no reset: it is only observed through count.
    always_ff @(posedge clk) begin
        if (acc0) begin
            mem[wr_ptr] <= '{pc: req0_pc_i, bta: req0_bta_i, br_type: req0_br_type_i};
        end
        if (acc1) begin
            mem[wr_ptr1] <= '{pc: req1_pc_i, bta: req1_bta_i, br_type: req1_br_type_i};
        end
    end
endmodule
